// File: rtl/fcmp_arbiter.sv
// Purpose: round-robin arbiter that shares one IEEE-754 single compare unit (lt/le/eq) among N_REQ requesters.
// Latency: accept at T, cmp_ready at T+1, resp_valid at T+2+k (k = unit delay) or T+1+TIMEOUT on timeout.
// Backpressure: one request in flight; others wait with req_ready=0 and hold their request. Responses cannot be stalled.
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready [N_REQ]      request handshake; req_ready is one-hot and only asserted in IDLE
//   req_x1/req_x2 [32*N_REQ]         operands, slice i = [32i+31:32i]
//   req_op [2*N_REQ]                 00 lt, 01 le, 10 eq, 11 treated as lt
//   resp_valid [N_REQ], resp_y,      one-cycle one-hot response strobe with result and timeout flag
//   resp_err
//   cmp_x1/cmp_x2/cmp_op/cmp_ready   operands and op to the shared compare unit, held for the whole BUSY state
//   cmp_valid/cmp_y                  compare unit result; ignored outside BUSY
module fcmp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_x1,
    input  logic [32*N_REQ-1:0]   req_x2,
    input  logic [2*N_REQ-1:0]    req_op,
    output logic [N_REQ-1:0]      resp_valid,
    output logic                  resp_y,
    output logic                  resp_err,
    output logic [31:0]           cmp_x1,
    output logic [31:0]           cmp_x2,
    output logic [1:0]            cmp_op,
    output logic                  cmp_ready,
    input  logic                  cmp_valid,
    input  logic                  cmp_y
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [PW:0]   N_W      = (PW + 1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  gnt_q, gnt_d;
    logic [31:0]    x1_q, x1_d;
    logic [31:0]    x2_q, x2_d;
    logic [1:0]     op_q, op_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           y_q, y_d;
    logic           err_q, err_d;

    // Winner search results
    logic           win_found;
    logic [PW-1:0]  win_idx;
    logic [PW:0]    cand;
    logic [31:0]    sel_x1;
    logic [31:0]    sel_x2;
    logic [1:0]     sel_op;
    logic [N_REQ-1:0] grant_oh;

    // Scan requesters starting at ptr_q, wrapping modulo N_REQ. The
    // candidate index is kept one bit wider so the wrap is a single subtract.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!win_found && req_valid[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // Operand mux and one-hot grant for the winner.
    always_comb begin
        sel_x1   = '0;
        sel_x2   = '0;
        sel_op   = '0;
        grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_x1      = req_x1[32*i +: 32];
                sel_x2      = req_x2[32*i +: 32];
                sel_op      = req_op[2*i +: 2];
                grant_oh[i] = win_found;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    x1_d    = sel_x1;
                    x2_d    = sel_x2;
                    // Reserved op is normalised to lt so the unit never sees 11.
                    op_d    = (sel_op == 2'b11) ? 2'b00 : sel_op;
                    gnt_d   = win_idx;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cmp_valid) begin
                    y_d     = cmp_y;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    y_d     = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                // Next search starts just after the requester that was served.
                ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // req_ready is a combinational path from req_valid, so it is masked
    // explicitly while reset is held; every other output decodes flops.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant_oh : '0;

    assign cmp_ready = (state_q == ST_BUSY);
    assign cmp_x1    = x1_q;
    assign cmp_x2    = x2_q;
    assign cmp_op    = op_q;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = (state_q == ST_RESP) && (gnt_q == PW'(i));
        end
    end

    assign resp_y   = (state_q == ST_RESP) & y_q;
    assign resp_err = (state_q == ST_RESP) & err_q;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Purpose: directed bench for fcmp_arbiter with a behavioural compare unit of programmable delay.
// Latency: checks grant, BUSY and response cycle counts against hand-computed values.
// Backpressure: requesters hold req_valid until granted, then drop it.
module tb_fcmp_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_x1;
    logic [32*N-1:0]  req_x2;
    logic [2*N-1:0]   req_op;
    logic [N-1:0]     resp_valid;
    logic             resp_y;
    logic             resp_err;
    logic [31:0]      cmp_x1;
    logic [31:0]      cmp_x2;
    logic [1:0]       cmp_op;
    logic             cmp_ready;
    logic             cmp_valid;
    logic             cmp_y;

    int   dly = 0;        // unit response delay in cycles after cmp_ready; -1 = never
    logic stray = 1'b0;   // forces cmp_valid regardless of cmp_ready
    int   busy_cyc = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fcmp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .resp_err   (resp_err),
        .cmp_x1     (cmp_x1),
        .cmp_x2     (cmp_x2),
        .cmp_op     (cmp_op),
        .cmp_ready  (cmp_ready),
        .cmp_valid  (cmp_valid),
        .cmp_y      (cmp_y)
    );

    always #5 clk = ~clk;

    // Total-order key for non-NaN floats.
    function automatic logic [31:0] okey(input logic [31:0] a);
        return a[31] ? ~a : (a | 32'h8000_0000);
    endfunction

    function automatic logic fcmp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic both_zero, eq, lt;
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        eq        = both_zero || (a == b);
        lt        = !both_zero && (okey(a) < okey(b));
        case (op)
            2'b01:   return lt || eq;
            2'b10:   return eq;
            default: return lt;
        endcase
    endfunction

    assign cmp_valid = (cmp_ready && dly >= 0 && busy_cyc == dly) || stray;
    assign cmp_y     = fcmp(cmp_x1, cmp_x2, cmp_op);

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        busy_cyc <= cmp_ready ? busy_cyc + 1 : 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Grant/response for a requester that holds req_valid until granted.
    task automatic serve_held(input int idx, input string tag);
        int w;
        w = 0;
        while (req_ready == '0 && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_gnt"}, 64'(req_ready), 64'(1 << idx));
        step();
        req_valid[idx] = 1'b0;
        w = 0;
        while (resp_valid == '0 && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_rsp"}, 64'(resp_valid), 64'(1 << idx));
        chk({tag, "_y"}, 64'({resp_err, resp_y}), 64'(2'b01));
        step();
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [1:0]  op;
        int          dly;
        int          gnt;
        logic [1:0]  exp_op;
        logic        y;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   t0;
        int   w;
        logic stable;

        // Vectors run back to back; the expected winner follows the pointer
        // left by the previous vector (starting from 0 after reset).
        tbl[0] = '{4'b0001, 32'h3F80_0000, 32'h4000_0000, 2'b00,  0, 0, 2'b00, 1'b1, 1'b0,  2};
        tbl[1] = '{4'b1111, 32'h3F80_0000, 32'h3F80_0000, 2'b10,  0, 1, 2'b10, 1'b1, 1'b0,  2};
        tbl[2] = '{4'b1111, 32'h4000_0000, 32'h3F80_0000, 2'b10,  0, 2, 2'b10, 1'b0, 1'b0,  2};
        tbl[3] = '{4'b1001, 32'h4000_0000, 32'h3F80_0000, 2'b00,  0, 3, 2'b00, 1'b0, 1'b0,  2};
        tbl[4] = '{4'b1001, 32'h3F80_0000, 32'h3F80_0000, 2'b01,  0, 0, 2'b01, 1'b1, 1'b0,  2};
        tbl[5] = '{4'b0001, 32'hBF80_0000, 32'h0000_0000, 2'b11,  0, 0, 2'b00, 1'b1, 1'b0,  2};
        tbl[6] = '{4'b0100, 32'h4000_0000, 32'h3F80_0000, 2'b01,  3, 2, 2'b01, 1'b0, 1'b0,  5};
        tbl[7] = '{4'b0010, 32'h3F80_0000, 32'h4000_0000, 2'b00, -1, 1, 2'b00, 1'b0, 1'b1, 16};
        tbl[8] = '{4'b0110, 32'hBF80_0000, 32'h3F80_0000, 2'b00,  0, 2, 2'b00, 1'b1, 1'b0,  2};
        tbl[9] = '{4'b0011, 32'h0000_0000, 32'h8000_0000, 2'b10,  0, 0, 2'b10, 1'b1, 1'b0,  2};

        req_valid = '0;
        req_x1    = '0;
        req_x2    = '0;
        req_op    = '0;

        // Reset state
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp", 64'({resp_valid, resp_y, resp_err}), 64'(0));
        chk("rst_cmp", 64'({cmp_ready, cmp_op, cmp_x1, cmp_x2}), 64'(0));
        rst = 1'b0;
        step();
        chk("idle_cmp_ready", 64'(cmp_ready), 64'(0));

        // cmp_valid while idle must be ignored
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_resp", 64'({resp_valid, cmp_ready}), 64'(0));
        end
        stray = 1'b0;

        // Table-driven single transactions
        for (int n = 0; n < 10; n++) begin
            v   = tbl[n];
            dly = v.dly;
            for (int i = 0; i < N; i++) begin
                req_x1[32*i +: 32] = (i == v.gnt) ? v.x1 : 32'h7F00_0010 + 32'(i);
                req_x2[32*i +: 32] = (i == v.gnt) ? v.x2 : 32'h7F00_0020 + 32'(i);
                req_op[2*i +: 2]   = (i == v.gnt) ? v.op : 2'b10;
            end
            req_valid = v.mask;
            #1;
            t0 = cyc;
            chk($sformatf("v%0d_req_ready", n), 64'(req_ready), 64'(1 << v.gnt));
            step();
            req_valid = '0;
            chk($sformatf("v%0d_cmp_ready", n), 64'(cmp_ready), 64'(1));
            chk($sformatf("v%0d_cmp_opnds", n), {cmp_x1, cmp_x2}, {v.x1, v.x2});
            chk($sformatf("v%0d_cmp_op", n), 64'(cmp_op), 64'(v.exp_op));
            stable = 1'b1;
            w = 0;
            while (resp_valid == '0 && w < 40) begin
                if (cmp_x1 !== v.x1 || cmp_x2 !== v.x2 || cmp_op !== v.exp_op) stable = 1'b0;
                step();
                w++;
            end
            chk($sformatf("v%0d_stable", n), 64'(stable), 64'(1));
            chk($sformatf("v%0d_latency", n), 64'(cyc - t0), 64'(v.lat));
            chk($sformatf("v%0d_resp_valid", n), 64'(resp_valid), 64'(1 << v.gnt));
            chk($sformatf("v%0d_y_err", n), 64'({resp_err, resp_y}), 64'({v.err, v.y}));
            chk($sformatf("v%0d_cmp_drop", n), 64'(cmp_ready), 64'(0));
            step();
            chk($sformatf("v%0d_resp_once", n), 64'(resp_valid), 64'(0));
        end

        // Reset during BUSY: ptr is 1 here, so 0101 grants requester 2 first.
        dly = -1;
        for (int i = 0; i < N; i++) begin
            req_x1[32*i +: 32] = 32'h3F80_0000;
            req_x2[32*i +: 32] = 32'h3F80_0000;
            req_op[2*i +: 2]   = 2'b10;
        end
        req_valid = 4'b0101;
        #1;
        chk("rb_gnt", 64'(req_ready), 64'(4'b0100));
        step();
        step();
        chk("rb_busy", 64'(cmp_ready), 64'(1));
        rst = 1'b1;
        #1;
        chk("rb_cmp_drop", 64'({cmp_ready, cmp_op, cmp_x1, cmp_x2}), 64'(0));
        chk("rb_req_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rb_no_resp", 64'({resp_valid, resp_y, resp_err}), 64'(0));
        end
        rst = 1'b0;
        dly = 0;
        #1;
        // ptr back at 0, so requester 0 wins; requester 2 is then re-granted.
        serve_held(0, "rb_r0");
        serve_held(2, "rb_r2");

        // ptr=3 after serving 2: requests 0 and 3 together -> 3 then 0
        req_valid = 4'b1001;
        #1;
        serve_held(3, "wrap_r3");
        serve_held(0, "wrap_r0");

        // Reset in IDLE, then all four held: grants every 3 cycles in order
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req_valid = 4'b1111;
        #1;
        t0 = cyc;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rr%0d_gnt", k), 64'(req_ready), 64'(1 << k));
            chk($sformatf("rr%0d_time", k), 64'(cyc - t0), 64'(3 * k));
            step();
            req_valid[k] = 1'b0;
            chk($sformatf("rr%0d_busy", k), 64'(cmp_ready), 64'(1));
            step();
            chk($sformatf("rr%0d_rsp", k), 64'({resp_valid, resp_err, resp_y}), 64'({4'(1 << k), 2'b01}));
            step();
        end
        // ptr must have wrapped to 0: 0 beats 3
        req_valid = 4'b1001;
        #1;
        serve_held(0, "ptr0_r0");
        serve_held(3, "ptr0_r3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
